// File: rtl/pc_ir_unit.sv
// Program counter, instruction register and ALUOut holding register for the
// multicycle MIPS-subset core; also decodes instruction fields and counts fetches.
module pc_ir_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   PCWrite,
  input  logic                   PCWriteCond,
  input  logic [1:0]             PCSource,
  input  logic                   IRWrite,
  input  logic                   zero,
  input  logic [31:0]            alu_result,
  input  logic [31:0]            mem_rdata,
  output logic [31:0]            pc,
  output logic [31:0]            instr,
  output logic [5:0]             opCode,
  output logic [4:0]             rs,
  output logic [4:0]             rt,
  output logic [4:0]             rd,
  output logic [5:0]             funct,
  output logic [31:0]            imm_sext,
  output logic [31:0]            imm_sext_sl2,
  output logic [31:0]            alu_out,
  output logic                   misalign_err,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [1:0] {
    SRC_ALU    = 2'b00,
    SRC_BRANCH = 2'b01,
    SRC_JUMP   = 2'b10,
    SRC_HOLD   = 2'b11
  } pc_src_e;

  logic [31:0]            pc_q, pc_d;
  logic [31:0]            instr_q, instr_d;
  logic [31:0]            alu_out_q;
  logic                   misalign_q, misalign_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic [31:0] next_pc;
  logic        pc_en;

  // Jump target uses the registered instr, so a same-cycle IR load cannot
  // redirect the jump being taken.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    next_pc = pc_q;
    unique case (pc_src_e'(PCSource))
      SRC_ALU:    next_pc = alu_result;
      SRC_BRANCH: next_pc = alu_out_q;
      SRC_JUMP:   next_pc = {pc_q[31:28], instr_q[25:0], 2'b00};
      SRC_HOLD:   next_pc = pc_q;
      default:    next_pc = pc_q;
    endcase
  end

  assign pc_en = PCWrite | (PCWriteCond & zero);

  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    instr_d    = instr_q;
    count_d    = count_q;
    if (pc_en) begin
      if (next_pc[1:0] == 2'b00) pc_d = next_pc;
      else                       misalign_d = 1'b1;
    end
    if (IRWrite) begin
      instr_d = mem_rdata;
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      alu_out_q  <= '0;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      alu_out_q  <= alu_result;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign pc           = pc_q;
  assign instr        = instr_q;
  assign alu_out      = alu_out_q;
  assign misalign_err = misalign_q;
  assign instr_count  = count_q;

  assign opCode       = instr_q[31:26];
  assign rs           = instr_q[25:21];
  assign rt           = instr_q[20:16];
  assign rd           = instr_q[15:11];
  assign funct        = instr_q[5:0];
  assign imm_sext     = {{16{instr_q[15]}}, instr_q[15:0]};
  assign imm_sext_sl2 = {imm_sext[29:0], 2'b00};

endmodule

// File: tb/tb_pc_ir_unit.sv
// Self-checking bench for pc_ir_unit: directed scenarios plus randomized
// stimulus compared against a behavioural model of the PC/IR datapath.
module tb_pc_ir_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          PCWrite, PCWriteCond, IRWrite, zero;
  logic [1:0]    PCSource;
  logic [31:0]   alu_result, mem_rdata;
  logic [31:0]   pc, instr, imm_sext, imm_sext_sl2, alu_out;
  logic [5:0]    opCode, funct;
  logic [4:0]    rs, rt, rd;
  logic          misalign_err;
  logic [CW-1:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_alu;
  logic        m_err;
  int          m_count;

  pc_ir_unit #(.RESET_PC(32'h0000_0000), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCSource(PCSource), .IRWrite(IRWrite), .zero(zero),
    .alu_result(alu_result), .mem_rdata(mem_rdata), .pc(pc), .instr(instr),
    .opCode(opCode), .rs(rs), .rt(rt), .rd(rd), .funct(funct),
    .imm_sext(imm_sext), .imm_sext_sl2(imm_sext_sl2), .alu_out(alu_out),
    .misalign_err(misalign_err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_alu = 32'h0; m_err = 1'b0; m_count = 0;
  endtask

  // One clock edge of the datapath as described by its load rules.
  task automatic model_edge();
    logic [31:0] target;
    case (PCSource)
      2'd0:    target = alu_result;
      2'd1:    target = m_alu;
      2'd2:    target = (m_pc & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
      default: target = m_pc;
    endcase
    if (PCWrite || (PCWriteCond && zero)) begin
      if (target % 4 == 0) m_pc = target;
      else                 m_err = 1'b1;
    end
    if (IRWrite) begin
      m_instr = mem_rdata;
      m_count = (m_count + 1) % (1 << CW);
    end
    m_alu = alu_result;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] sx;
    sx = (m_instr[15] ? 32'hFFFF_0000 : 32'h0) | (m_instr & 32'h0000_FFFF);
    check({tag, ".pc"},      pc, m_pc);
    check({tag, ".instr"},   instr, m_instr);
    check({tag, ".opCode"},  32'(opCode), m_instr >> 26);
    check({tag, ".rs"},      32'(rs), (m_instr >> 21) & 32'h1F);
    check({tag, ".rt"},      32'(rt), (m_instr >> 16) & 32'h1F);
    check({tag, ".rd"},      32'(rd), (m_instr >> 11) & 32'h1F);
    check({tag, ".funct"},   32'(funct), m_instr & 32'h3F);
    check({tag, ".sext"},    imm_sext, sx);
    check({tag, ".sext_sl2"}, imm_sext_sl2, sx * 4);
    check({tag, ".alu_out"}, alu_out, m_alu);
    check({tag, ".err"},     32'(misalign_err), 32'(m_err));
    check({tag, ".count"},   32'(instr_count), 32'(m_count));
  endtask

  // Drive inputs away from the edge, advance one edge, then compare.
  task automatic step(input logic pw, input logic pwc, input logic [1:0] src,
                      input logic irw, input logic z, input logic [31:0] alu,
                      input logic [31:0] mem, input string tag);
    PCWrite = pw; PCWriteCond = pwc; PCSource = src; IRWrite = irw; zero = z;
    alu_result = alu; mem_rdata = mem;
    #1;
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    PCWrite = 0; PCWriteCond = 0; PCSource = 2'b00; IRWrite = 0; zero = 0;
    alu_result = 0; mem_rdata = 0;
  endtask

  task automatic reset_cycle();
    reset = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    model_reset();
    #2;
    check_all("reset_async");
    @(posedge clk); #1;
    check_all("reset_held");
    reset = 1'b1;

    // 1: first fetch with PC increment
    step(1, 0, 2'b00, 1, 0, 32'd4, 32'h2008_0005, "t1");
    check("t1.instr_c",  instr, 32'h2008_0005);
    check("t1.opCode_c", 32'(opCode), 32'h08);
    check("t1.sext_c",   imm_sext, 32'd5);
    check("t1.pc_c",     pc, 32'd4);
    check("t1.count_c",  32'(instr_count), 32'd1);

    // 2: jump keeps pc[31:28]
    step(1, 0, 2'b00, 1, 0, 32'h4000_0008, 32'h0800_0010, "t2a");
    step(1, 0, 2'b10, 0, 0, 32'h0, 32'h0, "t2b");
    check("t2.pc_c", pc, 32'h4000_0040);

    // 3: branch taken only when zero is set
    step(0, 0, 2'b00, 0, 0, 32'h20, 32'h0, "t3a");
    check("t3.alu_out_c", alu_out, 32'h20);
    step(0, 1, 2'b01, 0, 0, 32'h20, 32'h0, "t3b");
    check("t3.pc_hold_c", pc, 32'h4000_0040);
    step(0, 1, 2'b01, 0, 1, 32'h20, 32'h0, "t3c");
    check("t3.pc_taken_c", pc, 32'h20);

    // 4: misaligned load is dropped and flagged; aligned load still works
    step(1, 0, 2'b00, 0, 0, 32'h6, 32'h0, "t4a");
    check("t4.pc_c",  pc, 32'h20);
    check("t4.err_c", 32'(misalign_err), 32'd1);
    step(1, 0, 2'b00, 0, 0, 32'h8, 32'h0, "t4b");
    check("t4.pc2_c",  pc, 32'h8);
    check("t4.err2_c", 32'(misalign_err), 32'd1);

    // 5: same-cycle IR and PC load uses the old instr for the jump
    step(0, 0, 2'b00, 1, 0, 32'h0, 32'h0800_0010, "t5a");
    step(1, 0, 2'b10, 1, 0, 32'h0, 32'hFFFF_FFFF, "t5b");
    check("t5.pc_c",    pc, 32'h40);
    check("t5.instr_c", instr, 32'hFFFF_FFFF);
    check("t5.sext_c",  imm_sext, 32'hFFFF_FFFF);

    // 6: counter wraps at 2^CW
    idle_inputs();
    reset_cycle();
    for (int i = 0; i < 17; i++)
      step(0, 0, 2'b00, 1, 0, 32'h0, 32'h1000_0000 + 32'(i), "t6");
    check("t6.count_c", 32'(instr_count), 32'd1);

    // Randomized traffic; mostly aligned ALU results so the PC moves around
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      step(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
           a, $urandom, "rnd");
      if (i == 200) begin
        idle_inputs();
        reset_cycle();
      end
    end

    // Async reset between edges must clear everything without a clock
    step(1, 0, 2'b00, 1, 0, 32'h0000_0104, 32'h8C22_FFF0, "pre_rst");
    step(1, 0, 2'b00, 0, 0, 32'h0000_0003, 32'h0, "pre_rst_err");
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("mid_rst");
    check("mid_rst.pc_c", pc, 32'h0);
    check("mid_rst.err_c", 32'(misalign_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    step(1, 0, 2'b00, 1, 0, 32'h0000_000C, 32'h1234_5678, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_ir_unit.md
Name: pc_ir_unit

Overview:
- Program counter, instruction register and ALUOut holding register for the multicycle MIPS-subset core.
- Sits directly downstream of the multicycle control FSM. It consumes PCWrite, PCWriteCond, PCSource and IRWrite, and produces the opCode field the FSM decodes.
- Forms the next PC from the incremented value, the branch target or the jump target.
- Flags misaligned PC loads and counts fetched instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- COUNT_WIDTH, 32, width of the fetched-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- PCWrite  in  1  unconditional PC load enable.
- PCWriteCond  in  1  PC load enable qualified by zero.
- PCSource  in  2  next-PC select.
- IRWrite  in  1  instruction register load enable.
- zero  in  1  ALU zero flag, same cycle.
- alu_result  in  32  combinational ALU output.
- mem_rdata  in  32  memory read data at address pc.
- pc  out  32  current PC.
- instr  out  32  instruction register.
- opCode  out  6  instr[31:26].
- rs  out  5  instr[25:21].
- rt  out  5  instr[20:16].
- rd  out  5  instr[15:11].
- funct  out  6  instr[5:0].
- imm_sext  out  32  sign-extended instr[15:0].
- imm_sext_sl2  out  32  imm_sext shifted left by 2.
- alu_out  out  32  ALUOut register.
- misalign_err  out  1  sticky misaligned-PC-load flag.
- instr_count  out  COUNT_WIDTH  number of IR loads.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC, instr=0, alu_out=0, misalign_err=0, instr_count=0.
  - Outputs take these values immediately; there is no clock dependency.
  - instr=0 decodes as opCode 6'b000000 (R-type, funct 0 = nop).
- alu_out captures alu_result on every rising edge, unconditionally; one-cycle latency.
- Next-PC mux (combinational):
  - 2'b00: alu_result.
  - 2'b01: alu_out (branch target).
  - 2'b10: {pc[31:28], instr[25:0], 2'b00}.
  - 2'b11: pc (hold; reserved).
- pc_en = PCWrite | (PCWriteCond & zero).
- When pc_en=1 and next_pc[1:0]==2'b00, pc <= next_pc on the edge.
- When pc_en=1 and next_pc[1:0]!=2'b00:
  - pc is unchanged.
  - misalign_err <= 1 and stays set until reset.
  - Later aligned loads still proceed normally.
- When IRWrite=1: instr <= mem_rdata, and instr_count <= instr_count+1, wrapping modulo 2^COUNT_WIDTH.
- Simultaneous PC and IR load (IRWrite=1 with pc_en=1 in the same cycle):
  - IR captures the word at the old pc.
  - The jump target is formed from the old instr value, not mem_rdata.
- Field outputs (opCode, rs, rt, rd, funct, imm_sext, imm_sext_sl2) are purely combinational from the instr register, with no extra latency.
- imm_sext = {{16{instr[15]}}, instr[15:0]}.
- imm_sext_sl2 = {imm_sext[29:0], 2'b00}.
- PCWrite and PCWriteCond both asserted: behaves as PCWrite alone.
- Reset asserted mid-sequence aborts any pending load. The first edge after reset deassertion may load normally.
- No internal state machine beyond the registers. Sequencing is owned by the control FSM.

Test Plan:
1. Reset then release; IRWrite=1, mem_rdata=32'h2008_0005, PCWrite=1, PCSource=00, alu_result=4 -> instr=32'h2008_0005, opCode=6'b001000, imm_sext=5, pc=4, instr_count=1.
2. Jump: instr=32'h0800_0010, pc=32'h4000_0008, PCWrite=1, PCSource=10 -> pc=32'h4000_0040.
3. Branch:
   - First cycle: alu_result=32'h0000_0020, so alu_out=0x20 after the edge.
   - Next cycle: PCWriteCond=1, PCSource=01, zero=0 -> pc unchanged.
   - Repeat with zero=1 -> pc=0x20.
4. Misalign: PCWrite=1, PCSource=00, alu_result=32'h0000_0006 -> pc unchanged, misalign_err=1. A following aligned load of 8 -> pc=8, misalign_err still 1.
5. Same-cycle IR and PC load: instr=J to 0x40, mem_rdata=32'hFFFF_FFFF, IRWrite=1, PCWrite=1, PCSource=10 -> pc=0x40 (from the old instr), instr=32'hFFFF_FFFF, imm_sext=32'hFFFF_FFFF.
6. Counter and reset:
   - With COUNT_WIDTH=4, 17 IRWrite pulses -> instr_count=1.
   - Assert reset between clock edges -> all outputs return to reset values without waiting for a clock edge.
